// File: rtl/scan_decoder.sv
// scan_decoder: registered binary-to-one-hot select driver for the pad/LED matrix.
// Manual mode decodes din; scan mode steps sel every max(div, BLANK)+1 cycles.
module scan_decoder #(
    parameter int SEL_W = 2,
    parameter int DIV_W = 8,
    parameter int BLANK = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       din,
    input  logic [DIV_W-1:0]       div,
    output logic [(1<<SEL_W)-1:0]  q,
    output logic [SEL_W-1:0]       sel,
    output logic                   tick,
    output logic                   wrap
);
    localparam int N = 1 << SEL_W;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] deff;
    logic [SEL_W-1:0] sel_nxt;
    logic [SEL_W-1:0] sel_inc;
    logic [N-1:0]     q_nxt;
    logic             tick_nxt;
    logic             wrap_nxt;
    logic             step;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // With blanking enabled a zero divisor would leave q permanently blank,
    // so the effective period is never shorter than one blank + one lit cycle.
    assign deff    = ((BLANK != 0) && (div == '0)) ? DIV_W'(1) : div;
    // >= so that lowering div below the running count steps at once.
    assign step    = (cnt >= deff);
    assign sel_inc = sel + SEL_W'(1);

    always_comb begin
        q_nxt    = '0;
        sel_nxt  = sel;
        cnt_nxt  = cnt;
        tick_nxt = 1'b0;
        wrap_nxt = 1'b0;
        if (en) begin
            if (!mode) begin
                sel_nxt = din;
                q_nxt   = onehot(din);
                cnt_nxt = '0;
            end else if (step) begin
                sel_nxt  = sel_inc;
                cnt_nxt  = '0;
                tick_nxt = 1'b1;
                wrap_nxt = (sel == SEL_LAST);
                q_nxt    = (BLANK != 0) ? '0 : onehot(sel_inc);
            end else begin
                cnt_nxt = cnt + DIV_W'(1);
                q_nxt   = onehot(sel);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            sel  <= '0;
            cnt  <= '0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            sel  <= sel_nxt;
            cnt  <= cnt_nxt;
            tick <= tick_nxt;
            wrap <= wrap_nxt;
        end
    end
endmodule
